// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: grants req/gnt after a configurable wait,
// returns in-order read data or an error a fixed number of cycles after each grant.
//
// state  | meaning
// S_IDLE | no request pending; with GNT_WAIT=0 grants directly from here
// S_WAIT | request seen, counting wait cycles in wcnt until the grant
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0004_0080,
  parameter int          DEPTH      = 64,
  parameter int          GNT_WAIT   = 0,
  parameter int          RVALID_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [31:0]              addr_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  input  logic                     prog_we_i,
  input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
  input  logic [31:0]              prog_wdata_i
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [2:0] WAIT_CNT = 3'(GNT_WAIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wcnt, wcnt_nxt;
  logic        gnt;

  logic [31:0] mem [DEPTH];

  logic [32:0]      diff;
  logic [31:0]      off;
  logic             below;
  logic [IDX_W-1:0] idx;
  logic             dec_err;
  logic [31:0]      rd_data;

  logic [RVALID_LAT-1:0] pipe_vld;
  logic                  pipe_err [RVALID_LAT];
  logic [31:0]           pipe_dat [RVALID_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Dropping req_i mid-wait abandons the request; the next one waits afresh.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (GNT_WAIT != 0) begin
      if (state == S_IDLE) begin
        if (req_i) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = 3'd1;
        end
      end else begin
        if (!req_i || (wcnt == WAIT_CNT)) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt + 3'd1;
        end
      end
    end
  end

  always_comb begin
    gnt = 1'b0;
    if (!rst_i && req_i) begin
      if (GNT_WAIT == 0) gnt = 1'b1;
      else               gnt = (state == S_WAIT) && (wcnt == WAIT_CNT);
    end
  end

  assign gnt_o = gnt;

  // The 33rd bit of the subtraction is the borrow, i.e. addr_i below the window.
  assign diff    = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign off     = diff[31:0];
  assign below   = diff[32];
  assign idx     = off[IDX_W+1:2];
  assign dec_err = below || (off[31:2] >= 30'(DEPTH)) || (off[1:0] != 2'b00);
  assign rd_data = dec_err ? 32'h0 : mem[idx];

  always_ff @(posedge clk_i) begin
    if (prog_we_i) mem[prog_addr_i] <= prog_wdata_i;
  end

  // Payload only moves with a valid so the last stage holds its value between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int k = 0; k < RVALID_LAT; k++) begin
        pipe_err[k] <= 1'b0;
        pipe_dat[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= gnt;
      if (gnt) begin
        pipe_err[0] <= dec_err;
        pipe_dat[0] <= rd_data;
      end
      for (int k = 1; k < RVALID_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_err[k] <= pipe_err[k-1];
          pipe_dat[k] <= pipe_dat[k-1];
        end
      end
    end
  end

  assign rvalid_o = pipe_vld[RVALID_LAT-1];
  assign err_o    = pipe_err[RVALID_LAT-1];
  assign rdata_o  = pipe_dat[RVALID_LAT-1];

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Memory-side responder for the core instruction-fetch req/gnt/rvalid protocol: the slave that answers `instr_req_o`/`instr_addr_o` from the instruction memory decoder. It holds a word-addressed instruction store, grants requests after a configurable number of wait cycles, and returns in-order read data or an error response a fixed number of cycles after each grant. A preload port fills the store before the core runs; the block serves as the behavioural ROM in decoder/core benches.

## Interface
- `BASE_ADDR`, 32'h0004_0080, byte address of word 0; must be word-aligned.
- `DEPTH`, 64, number of 32-bit words; power of two, 2..4096.
- `GNT_WAIT`, 0, cycles `req_i` must be high before `gnt_o` pulses; 0..7.
- `RVALID_LAT`, 1, cycles from grant edge to `rvalid_o`; 1..4.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  fetch request.
- `addr_i`  in  32  byte address; stable while `req_i` high and `gnt_o` low.
- `gnt_o`  out  1  request accepted this cycle.
- `rvalid_o`  out  1  response valid, one cycle per granted request.
- `rdata_o`  out  32  read data, valid with `rvalid_o`.
- `err_o`  out  1  error response, valid with `rvalid_o`.
- `prog_we_i`  in  1  preload write enable.
- `prog_addr_i`  in  $clog2(DEPTH)  preload word index.
- `prog_wdata_i`  in  32  preload data.

## Operation
- Grant FSM, states IDLE and WAIT, with 3-bit wait counter `wcnt`.
  - GNT_WAIT=0: stays in IDLE; `gnt_o = req_i` (combinational), one grant per cycle, back-to-back allowed.
  - GNT_WAIT>0: IDLE with `req_i` -> WAIT, `wcnt`=1. In WAIT, `wcnt` increments each cycle; `gnt_o`=1 when `wcnt`==GNT_WAIT and `req_i`. After grant: -> IDLE. Each request waits GNT_WAIT cycles, including back-to-back requests.
  - `req_i` dropped in WAIT: -> IDLE, `wcnt` cleared, no transaction.
- Decode at grant: `off = addr_i - BASE_ADDR` (32-bit, unsigned).
  - `idx = off[..2]`.
  - Error when `addr_i < BASE_ADDR`, or `off >> 2 >= DEPTH`, or `addr_i[1:0] != 0`.
  - Error response: `err_o`=1, `rdata_o`=32'h0. Otherwise `err_o`=0, `rdata_o`=mem[idx].
- Response pipe: RVALID_LAT stages of {valid, err, data}. The store is read at the grant edge into stage 1, then shifted one stage per cycle. Stage RVALID_LAT drives the outputs. Strictly in order; no backpressure on responses.
- Preload: on `prog_we_i`, mem[`prog_addr_i`] <= `prog_wdata_i`. Visible to grants from the next cycle. A grant in the same cycle as a write to the same word reads the old value.
- Store contents are undefined before preload and are not changed by reset.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0; FSM IDLE, `wcnt`=0, all pipe valids 0.
- Reset while responses are in flight discards them; no `rvalid_o` appears after reset for pre-reset grants.
- `req_i` while `rst_i` is high is not granted.
- Grant at edge T -> `rvalid_o` high during cycle T+RVALID_LAT, i.e. registered after RVALID_LAT edges.
- Throughput:
  - GNT_WAIT=0: 1 word/cycle.
  - Otherwise: 1 word per GNT_WAIT+1 cycles.
- Maximum in-flight responses = RVALID_LAT; no internal overflow is possible.
- `rdata_o`/`err_o` hold their last value when `rvalid_o`=0, except after reset (0).

## Test plan
- Setup: preload mem[i] = 32'hA000_0000+i for i=0..63; defaults (GNT_WAIT=0, RVALID_LAT=1). Stimulus: `req_i` high for 32 cycles with addr 32'h0004_0080 incrementing by 4. Required response:
  - `gnt_o` high all 32 cycles.
  - 32 consecutive `rvalid_o` pulses, each one cycle after its grant.
  - Data 32'hA000_0000..32'hA000_001F, `err_o`=0.
- Error decode: addr 32'h0004_007C, 32'h0004_0180 (index 64) and 32'h0004_0082. Required response: each yields `rvalid_o`=1, `err_o`=1, `rdata_o`=0.
- GNT_WAIT=2, RVALID_LAT=3, req held for 2 requests (addr +0, +4). Required response:
  - `gnt_o` pulses at cycles 2 and 5 after req rise.
  - `rvalid_o` at cycles 5 and 8 with 32'hA000_0000 and 32'hA000_0001.
- GNT_WAIT=3: `req_i` high 2 cycles then low. Required response: no `gnt_o`, no `rvalid_o`. A new req afterwards is granted after a full 3-cycle wait.
- Preload collision: `prog_we_i` to index 5 with 32'hDEAD_BEEF in the same cycle as a grant of 32'h0004_0094. Required response: old 32'hA000_0005 returned; the next grant of the same address returns 32'hDEAD_BEEF.
- RVALID_LAT=4: 3 back-to-back grants, then assert `rst_i` one cycle after the last grant. Required response:
  - Exactly one `rvalid_o`, from the first grant at the reset edge.
  - All outputs 0 after reset.
  - Store contents intact on the next fetch.
